dmem_access_unit: RTL

Load/store initiator that sits between the pipeline MEM stage and the word-addressed DataMemory. The memory reads asynchronously and writes synchronously. This block accepts one byte, halfword or word request at a time over a valid/ready handshake. It performs aligned word reads, read-modify-write for sub-word stores, and sign/zero extension for loads. It returns a one-cycle response pulse, with an error flag for misaligned, out-of-range or illegal requests.

---
 rtl/dmem_req_if.sv | 23 ++
 rtl/dmem_access_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_req_if.sv
// Request/response handshake between the MEM stage and the data memory access unit.
// Master issues one load/store at a time; slave answers with a one-cycle response pulse.
interface dmem_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store initiator for a word-addressed data memory with async read, sync write.
// Handles sub-word stores by read-modify-write and extends sub-word loads.
module dmem_access_unit #(
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  dmem_req_if.slave   bus,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WR, RESP
  } state_t;

  state_t      state, state_nx;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, merge_q;
  logic        accept, acc_err;
  logic [31:0] widx;
  logic [31:0] ld_ext, wr_word;

  assign accept = (state == IDLE) && bus.req_valid;
  assign widx   = {2'b00, bus.req_addr[31:2]};

  always_comb begin
    acc_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = bus.req_addr[0];
      3'b010:  acc_err = |bus.req_addr[1:0];
      3'b100:  acc_err = bus.req_we;
      3'b101:  acc_err = bus.req_we | bus.req_addr[0];
      default: acc_err = 1'b1;
    endcase
    if (widx >= MEM_DEPTH) acc_err = 1'b1;
  end

  // Lane selection is little-endian on the latched byte address
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = mem_dout[8*addr_q[1:0] +: 8];
    h = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{b[7]}}, b};
      3'b001:  ld_ext = {{16{h[15]}}, h};
      3'b100:  ld_ext = {24'h0, b};
      3'b101:  ld_ext = {16'h0, h};
      default: ld_ext = mem_dout;
    endcase
  end

  always_comb begin
    wr_word = merge_q;
    case (f3_q)
      3'b000:  wr_word[8*addr_q[1:0] +: 8] = wdata_q[7:0];
      3'b001:  wr_word[16*addr_q[1] +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= acc_err;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= 32'h0;
      end
      if (state == LOAD)   rdata_q <= ld_ext;
      if (state == RMW_RD) merge_q <= mem_dout;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (acc_err)                     state_nx = RESP;
          else if (!bus.req_we)            state_nx = LOAD;
          else if (bus.req_funct3[1])      state_nx = WR;
          else                             state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = WR;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset overrides everything so an in-flight access never reaches memory
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'h0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = 32'h0;
    mem_din        = 32'h0;
    if (reset) begin
      bus.req_ready = 1'b1;
    end else begin
      case (state)
        IDLE: bus.req_ready = 1'b1;
        LOAD, RMW_RD: begin
          mem_read = 1'b1;
          mem_addr = {addr_q[31:2], 2'b00};
        end
        WR: begin
          mem_write = 1'b1;
          mem_addr  = {addr_q[31:2], 2'b00};
          mem_din   = wr_word;
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = err_q;
          bus.resp_rdata = rdata_q;
        end
        default: ;
      endcase
    end
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule
